// File: rtl/display_pkg.sv
// Shared codes, FSM encoding and sizing helper for the digit scanner.
package display_pkg;

    localparam logic [3:0] DIG_MINUS = 4'd10;
    localparam logic [3:0] DIG_BLANK = 4'd15;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_COMMIT = 2'd2
    } state_e;

    // One position more than the BCD digits so a minus sign always fits.
    function automatic int NPOS(input int ndig);
        return ndig + 1;
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter: one add-3/shift step per asserted step cycle.
module bin2bcd_seq #(
    parameter int WIDTH = 16,
    parameter int NDIG  = 5
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                step,
    input  logic [WIDTH-1:0]    bin,
    output logic [4*NDIG-1:0]   bcd,
    output logic                last
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    logic [WIDTH-1:0]  bin_q;
    logic [4*NDIG-1:0] bcd_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [4*NDIG-1:0] adj;
    logic [4*NDIG-1:0] bcd_d;

    for (genvar gi = 0; gi < NDIG; gi++) begin : g_adj
        assign adj[4*gi +: 4] = (bcd_q[4*gi +: 4] >= 4'd5) ? bcd_q[4*gi +: 4] + 4'd3
                                                           : bcd_q[4*gi +: 4];
    end

    assign bcd_d = (adj << 1) | {{(4*NDIG-1){1'b0}}, bin_q[WIDTH-1]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bin_q <= '0;
            bcd_q <= '0;
            cnt_q <= '0;
        end else if (start) begin
            bin_q <= bin;
            bcd_q <= '0;
            cnt_q <= '0;
        end else if (step) begin
            bin_q <= bin_q << 1;
            bcd_q <= bcd_d;
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign bcd  = bcd_q;
    assign last = step && (cnt_q == CNT_W'(WIDTH - 1));

endmodule

// File: rtl/display_digit_scanner.sv
// Signed value -> blanked, sign-placed digit buffer, scanned four digits at a time
// through a scrollable window.
module display_digit_scanner
    import display_pkg::*;
#(
    parameter int WIDTH       = 16,
    parameter int NDIG        = 5,
    parameter int REFRESH_DIV = 100000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] value_in,
    input  logic             value_valid,
    input  logic             scroll_left,
    input  logic             scroll_right,
    output logic             busy,
    output logic             done,
    output logic [1:0]       toggle,
    output logic [3:0]       digit
);

    localparam int NP      = NPOS(NDIG);
    localparam int OFF_MAX = NP - 4;
    localparam int OFF_W   = $clog2(NP);
    localparam int CNT_W   = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;

    state_e            state_q;
    logic              busy_q;
    logic              done_q;
    logic              neg_q;
    logic [WIDTH-1:0]  mag_d;
    logic              start_d;
    logic              step_d;
    logic [4*NDIG-1:0] bcd;
    logic              last;

    logic [3:0]        disp_q [NP];
    logic [3:0]        disp_d [NP];
    logic [NDIG-1:0]   nz;
    logic [NDIG:0]     above;

    logic [CNT_W-1:0]  ref_cnt_q;
    logic [1:0]        toggle_q;
    logic [OFF_W-1:0]  off_q;
    logic [OFF_W-1:0]  idx_d;

    // -2^(WIDTH-1) negates to itself, which is the exact unsigned magnitude.
    assign mag_d   = value_in[WIDTH-1] ? (~value_in + WIDTH'(1)) : value_in;
    assign start_d = (state_q == ST_IDLE) && value_valid;
    assign step_d  = (state_q == ST_SHIFT);

    bin2bcd_seq #(
        .WIDTH (WIDTH),
        .NDIG  (NDIG)
    ) u_bin2bcd (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start_d),
        .step  (step_d),
        .bin   (mag_d),
        .bcd   (bcd),
        .last  (last)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            neg_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (value_valid) begin
                        neg_q   <= value_in[WIDTH-1];
                        state_q <= ST_SHIFT;
                        busy_q  <= 1'b1;
                    end
                end
                ST_SHIFT: begin
                    if (last) begin
                        state_q <= ST_COMMIT;
                    end
                end
                ST_COMMIT: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    // above[i]: some digit at position i or higher is nonzero.
    assign above[NDIG] = 1'b0;
    for (genvar gi = 0; gi < NDIG; gi++) begin : g_place
        assign nz[gi]    = (bcd[4*gi +: 4] != 4'd0);
        assign above[gi] = above[gi+1] | nz[gi];
        if (gi == 0) begin : g_units
            assign disp_d[gi] = bcd[3:0];
        end else begin : g_upper
            assign disp_d[gi] = above[gi]               ? bcd[4*gi +: 4] :
                                (neg_q && nz[gi-1])     ? DIG_MINUS      :
                                                          DIG_BLANK;
        end
    end
    assign disp_d[NDIG] = (neg_q && nz[NDIG-1]) ? DIG_MINUS : DIG_BLANK;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NP; i++) begin
                disp_q[i] <= (i == 0) ? 4'd0 : DIG_BLANK;
            end
        end else if (state_q == ST_COMMIT) begin
            for (int i = 0; i < NP; i++) begin
                disp_q[i] <= disp_d[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ref_cnt_q <= '0;
            toggle_q  <= 2'd0;
        end else if (ref_cnt_q == CNT_W'(REFRESH_DIV - 1)) begin
            ref_cnt_q <= '0;
            toggle_q  <= toggle_q + 2'd1;
        end else begin
            ref_cnt_q <= ref_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            off_q <= '0;
        end else if (scroll_left && !scroll_right && (off_q != OFF_W'(OFF_MAX))) begin
            off_q <= off_q + 1'b1;
        end else if (scroll_right && !scroll_left && (off_q != '0)) begin
            off_q <= off_q - 1'b1;
        end
    end

    assign idx_d  = off_q + OFF_W'(toggle_q);
    assign digit  = disp_q[idx_d];
    assign toggle = toggle_q;
    assign busy   = busy_q;
    assign done   = done_q;

endmodule

// File: tb/tb_display_digit_scanner.sv
// Directed bench for display_digit_scanner with a fast refresh divider.
module tb_display_digit_scanner;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] value_in = '0;
    logic        value_valid = 1'b0;
    logic        scroll_left = 1'b0;
    logic        scroll_right = 1'b0;
    logic        busy;
    logic        done;
    logic [1:0]  toggle;
    logic [3:0]  digit;

    int errors = 0;
    int checks = 0;

    display_digit_scanner #(
        .WIDTH       (16),
        .NDIG        (5),
        .REFRESH_DIV (4)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .value_in     (value_in),
        .value_valid  (value_valid),
        .scroll_left  (scroll_left),
        .scroll_right (scroll_right),
        .busy         (busy),
        .done         (done),
        .toggle       (toggle),
        .digit        (digit)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic scan(input string tag, input int e0, input int e1, input int e2, input int e3);
        int exp_d [4];
        exp_d = '{e0, e1, e2, e3};
        for (int t = 0; t < 4; t++) begin
            int n = 0;
            while (toggle !== 2'(t) && n < 40) begin
                @(negedge clk);
                n++;
            end
            chk($sformatf("%s_tog%0d", tag, t), 32'(toggle), 32'(t));
            chk($sformatf("%s_dig%0d", tag, t), 32'(digit), 32'(exp_d[t]));
        end
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (done !== 1'b1 && n < 60) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_done"}, 32'(done), 32'd1);
    endtask

    // Leaves the bench at the negedge where done is high.
    task automatic convert(input string tag, input logic [15:0] v);
        int n = 0;
        bit done_early = 0;
        value_in    = v;
        value_valid = 1'b1;
        @(negedge clk);
        value_valid = 1'b0;
        while (busy === 1'b1 && n < 40) begin
            if (done === 1'b1) done_early = 1;
            n++;
            @(negedge clk);
        end
        chk({tag, "_busy_cycles"}, 32'(n), 32'd17);
        chk({tag, "_done_after_busy"}, 32'(done), 32'd1);
        chk({tag, "_no_done_while_busy"}, 32'(done_early), 32'd0);
    endtask

    task automatic pulse_scroll(input logic l, input logic r);
        scroll_left  = l;
        scroll_right = r;
        @(negedge clk);
        scroll_left  = 1'b0;
        scroll_right = 1'b0;
    endtask

    initial begin
        // 1. reset state and refresh timing
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_toggle", 32'(toggle), 32'd0);
        chk("rst_digit", 32'(digit), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("tog_hold_3clk", 32'(toggle), 32'd0);
        @(negedge clk);
        chk("tog_adv_4clk", 32'(toggle), 32'd1);
        repeat (8) @(negedge clk);
        chk("tog_12clk", 32'(toggle), 32'd3);
        repeat (4) @(negedge clk);
        chk("tog_wrap_16clk", 32'(toggle), 32'd0);
        scan("reset_scan", 0, 15, 15, 15);

        // 2. -1234
        convert("m1234", 16'hFB2E);
        scan("m1234_scan", 4, 3, 2, 1);
        pulse_scroll(1'b1, 1'b0);
        pulse_scroll(1'b1, 1'b0);
        scan("m1234_win2", 2, 1, 10, 15);
        pulse_scroll(1'b0, 1'b1);
        pulse_scroll(1'b0, 1'b1);

        // 3. -32768 and window saturation
        convert("m32768", 16'h8000);
        scan("m32768_scan", 8, 6, 7, 2);
        pulse_scroll(1'b1, 1'b0);
        pulse_scroll(1'b1, 1'b0);
        scan("m32768_win2", 7, 2, 3, 10);
        pulse_scroll(1'b1, 1'b0);
        scan("m32768_sat", 7, 2, 3, 10);
        pulse_scroll(1'b1, 1'b1);
        scan("m32768_both", 7, 2, 3, 10);
        pulse_scroll(1'b0, 1'b1);
        scan("m32768_win1", 6, 7, 2, 3);
        pulse_scroll(1'b0, 1'b1);
        pulse_scroll(1'b0, 1'b1);
        scan("m32768_win0", 8, 6, 7, 2);

        // 4. zero and small positive
        convert("zero", 16'h0000);
        scan("zero_scan", 0, 15, 15, 15);
        pulse_scroll(1'b1, 1'b0);
        pulse_scroll(1'b1, 1'b0);
        scan("zero_win2", 15, 15, 15, 15);
        pulse_scroll(1'b0, 1'b1);
        pulse_scroll(1'b0, 1'b1);
        convert("p7", 16'd7);
        scan("p7_scan", 7, 15, 15, 15);

        // 5. load while busy is dropped; load in done cycle is taken
        value_in    = 16'd100;
        value_valid = 1'b1;
        @(negedge clk);
        value_valid = 1'b0;
        repeat (3) @(negedge clk);
        value_in    = 16'd5;
        value_valid = 1'b1;
        @(negedge clk);
        value_valid = 1'b0;
        wait_done("busyload");
        scan("busyload_scan", 0, 0, 1, 15);
        convert("p9", 16'd9);
        value_in    = 16'd42;
        value_valid = 1'b1;
        @(negedge clk);
        value_valid = 1'b0;
        chk("donecycle_accept_busy", 32'(busy), 32'd1);
        wait_done("p42");
        scan("p42_scan", 2, 4, 15, 15);

        // 6. reset mid-conversion
        begin
            bit done_seen = 0;
            value_in    = 16'd999;
            value_valid = 1'b1;
            @(negedge clk);
            value_valid = 1'b0;
            repeat (7) @(negedge clk);
            chk("abort_busy_before", 32'(busy), 32'd1);
            rst_n = 1'b0;
            #1;
            chk("abort_busy", 32'(busy), 32'd0);
            chk("abort_digit", 32'(digit), 32'd0);
            @(negedge clk);
            rst_n = 1'b1;
            repeat (30) begin
                @(negedge clk);
                if (done === 1'b1) done_seen = 1;
            end
            chk("abort_no_done", 32'(done_seen), 32'd0);
            scan("abort_scan", 0, 15, 15, 15);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
